// File: rtl/riscv_pkg.sv
// Shared types for the core and its memory blocks.
//   rdw_mode_t : same-address read-during-write policy for simple dual-port RAMs.
//   BYTE_W     : width of one byte lane, used for byte-enable slicing.
package riscv_pkg;

   typedef enum logic [0:0] {
      RDW_READ_FIRST  = 1'b0,   // colliding read returns the pre-write word
      RDW_WRITE_FIRST = 1'b1    // colliding read returns the merged new word
   } rdw_mode_t;

   localparam int BYTE_W = 8;

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-response output pipeline for bram_sdp_pipe: 1 or 2 register stages
// carrying a valid bit and a data word. Data registers only load when their
// input is valid, so the output word holds between responses.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid, in_data    : read request accepted this cycle / word read from storage
//   out_valid, out_data  : response pulse and response data
module bram_rd_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [READ_LATENCY:1]                 vld_pipe;
   logic [READ_LATENCY:1][DATA_WIDTH-1:0] data_pipe;

   // Stage 1 is the RAM output register; stage 2 (if present) is a plain
   // register, so writes landing after the read was accepted are not seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
      end else begin
         vld_pipe[1] <= in_valid;
         if (in_valid) data_pipe[1] <= in_data;
         for (int s = 2; s <= READ_LATENCY; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
         end
      end
   end

   assign out_valid = vld_pipe[READ_LATENCY];
   assign out_data  = data_pipe[READ_LATENCY];

endmodule

// File: rtl/bram_sdp_pipe.sv
// Simple dual-port block RAM with byte-masked writes, configurable
// same-address read-during-write policy and a 1- or 2-cycle pipelined read.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (memory is retained)
//   we, wbe, waddr, wdata : write request, per-byte enable, address, data
//   re, raddr           : read request and address
//   rdata, rvalid       : read response data (held between responses), response pulse
module bram_sdp_pipe
   import riscv_pkg::*;
#(
   parameter int        DEPTH          = 512,
   parameter int        ADDR_WIDTH     = $clog2(DEPTH),
   parameter int        DATA_WIDTH     = 32,
   parameter int        NUM_BYTES      = DATA_WIDTH / 8,
   parameter int        READ_LATENCY   = 1,
   parameter rdw_mode_t RDW_MODE       = RDW_READ_FIRST,
   parameter            RAM_STYLE_ATTR = "block"
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [NUM_BYTES-1:0]  wbe,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid
);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("bram_sdp_pipe: READ_LATENCY must be 1 or 2");
   end
   if ((DATA_WIDTH % BYTE_W) != 0 || NUM_BYTES * BYTE_W != DATA_WIDTH) begin : g_bad_width
      $error("bram_sdp_pipe: DATA_WIDTH must be a multiple of 8 and equal NUM_BYTES*8");
   end

   // Zero-initialised at configuration; never reset.
   (* ram_style = RAM_STYLE_ATTR *)
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   logic                  waddr_ok;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_word;

   // Only a non-power-of-two depth leaves addresses that fall off the end.
   if ((2 ** ADDR_WIDTH) > DEPTH) begin : g_sparse
      assign waddr_ok = (int'(waddr) < DEPTH);
   end else begin : g_dense
      assign waddr_ok = 1'b1;
   end

   assign wr_en = we && !reset && waddr_ok;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (wbe[i]) mem[waddr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
         end
      end
   end

   // Word presented to the output register. Read-first needs nothing extra:
   // the array still holds the old word at this edge. Write-first overlays
   // the enabled bytes of the colliding write.
   always_comb begin
      rd_word = mem[raddr];
      if (RDW_MODE == RDW_WRITE_FIRST && we && waddr == raddr) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (wbe[i]) rd_word[BYTE_W*i +: BYTE_W] = wdata[BYTE_W*i +: BYTE_W];
         end
      end
   end

   bram_rd_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (re),
      .in_data   (rd_word),
      .out_valid (rvalid),
      .out_data  (rdata)
   );

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// Four instances share one stimulus stream: {lat1,lat2} x {read-first,write-first}.
// Index k: 0=L1/RF 1=L1/WF 2=L2/RF 3=L2/WF.
module tb_bram_sdp_pipe;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        we, re;
   logic [3:0]  wbe;
   logic [8:0]  waddr, raddr;
   logic [31:0] wdata;
   logic [31:0] rd [4];
   logic        rv [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bram_sdp_pipe #(.READ_LATENCY(1), .RDW_MODE(RDW_READ_FIRST)) dut0 (
      .clk(clk), .reset(reset), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]));
   bram_sdp_pipe #(.READ_LATENCY(1), .RDW_MODE(RDW_WRITE_FIRST)) dut1 (
      .clk(clk), .reset(reset), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]));
   bram_sdp_pipe #(.READ_LATENCY(2), .RDW_MODE(RDW_READ_FIRST)) dut2 (
      .clk(clk), .reset(reset), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]));
   bram_sdp_pipe #(.READ_LATENCY(2), .RDW_MODE(RDW_WRITE_FIRST)) dut3 (
      .clk(clk), .reset(reset), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd[3]), .rvalid(rv[3]));

   // ---------------- reference model ----------------
   logic [31:0] mem_m [512];
   int          cyc = 0;
   int          due_q [4][$];
   logic [31:0] dat_q [4][$];
   logic [31:0] erd [4];
   logic        erv [4];

   // Called once per rising edge with the inputs that edge sampled.
   task automatic model_edge();
      logic [31:0] w;
      cyc++;
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            due_q[k].delete();
            dat_q[k].delete();
            erv[k] = 1'b0;
            erd[k] = '0;
         end
      end else begin
         if (re) begin
            for (int k = 0; k < 4; k++) begin
               w = mem_m[raddr];
               if ((k % 2) == 1 && we && waddr == raddr)
                  for (int b = 0; b < 4; b++) if (wbe[b]) w[8*b +: 8] = wdata[8*b +: 8];
               due_q[k].push_back(cyc + ((k < 2) ? 1 : 2) - 1);
               dat_q[k].push_back(w);
            end
         end
         if (we)
            for (int b = 0; b < 4; b++) if (wbe[b]) mem_m[waddr][8*b +: 8] = wdata[8*b +: 8];
         for (int k = 0; k < 4; k++) begin
            if (due_q[k].size() > 0 && due_q[k][0] == cyc) begin
               void'(due_q[k].pop_front());
               erd[k] = dat_q[k].pop_front();
               erv[k] = 1'b1;
            end else begin
               erv[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic w, input logic [3:0] be, input int wa,
                        input logic [31:0] wd, input logic r, input int ra);
      we = w; wbe = be; waddr = 9'(wa); wdata = wd; re = r; raddr = 9'(ra);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      drive(1, 4'hf, 3, 32'hFFFF_FFFF, 1, 3);  // ignored under reset
      for (int i = 0; i < 2; i++) begin
         step();
         for (int k = 0; k < 4; k++) begin
            total++;
            if (rv[k] !== 1'b0 || rd[k] !== 32'h0) begin
               bad++;
               $display("FAIL reset inst%0d: rvalid=%b rdata=%h want 0/00000000", k, rv[k], rd[k]);
            end
         end
      end
      reset = 1'b0;
      // never-written address and the address poked under reset both read zero
      drive(0, 0, 0, 0, 1, 400); step();
      drive(0, 0, 0, 0, 1, 3);   step();
      drive(0, 0, 0, 0, 0, 0);   step(); step();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rv[k] !== 1'b0 || rd[k] !== 32'h0) begin
            bad++;
            $display("FAIL zero_init inst%0d: rvalid=%b rdata=%h want 0/00000000", k, rv[k], rd[k]);
         end
      end
   endtask

   task automatic test_byte_enable();
      drive(1, 4'b1111, 5, 32'hAABB_CCDD, 0, 0); step();
      drive(1, 4'b0101, 5, 32'h1122_3344, 0, 0); step();
      drive(0, 0, 0, 0, 1, 5);                   step();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (rv[k] !== 1'b1 || rd[k] !== 32'hAA22_CC44) begin
            bad++;
            $display("FAIL byte_en inst%0d: rvalid=%b rdata=%h want 1/aa22cc44", k, rv[k], rd[k]);
         end
      end
      drive(0, 0, 0, 0, 0, 0); step();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rv[k] !== (k >= 2) || rd[k] !== 32'hAA22_CC44) begin
            bad++;
            $display("FAIL byte_en_l2 inst%0d: rvalid=%b rdata=%h want %b/aa22cc44", k, rv[k], rd[k], k >= 2);
         end
      end
   endtask

   task automatic test_collision();
      logic [31:0] want [4];
      logic [3:0]  be;
      int          a;
      for (int t = 0; t < 2; t++) begin
         be = (t == 0) ? 4'b1111 : 4'b0011;
         a  = (t == 0) ? 7 : 8;            // both start at zero
         want[0] = 32'h0; want[2] = 32'h0;
         want[1] = (t == 0) ? 32'hDEAD_BEEF : 32'h0000_BEEF;
         want[3] = want[1];
         drive(1, be, a, 32'hDEAD_BEEF, 1, a); step();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (rv[k] !== 1'b1 || rd[k] !== want[k]) begin
               bad++;
               $display("FAIL collision%0d inst%0d: rvalid=%b rdata=%h want 1/%h", t, k, rv[k], rd[k], want[k]);
            end
         end
         drive(0, 0, 0, 0, 0, 0); step();
         for (int k = 2; k < 4; k++) begin
            total++;
            if (rv[k] !== 1'b1 || rd[k] !== want[k]) begin
               bad++;
               $display("FAIL collision%0d inst%0d: rvalid=%b rdata=%h want 1/%h", t, k, rv[k], rd[k], want[k]);
            end
         end
      end
      // next-cycle read after the write sees the written word in every instance
      drive(0, 0, 0, 0, 1, 8); step();
      drive(0, 0, 0, 0, 0, 0); step();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rd[k] !== 32'h0000_BEEF) begin
            bad++;
            $display("FAIL write_then_read inst%0d: rdata=%h want 0000beef", k, rd[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         drive(1, 4'hf, i, 32'(i * 3), 0, 0); step();
      end
      for (int j = 0; j < 18; j++) begin
         if (j < 16) drive(0, 0, 0, 0, 1, j);
         else        drive(0, 0, 0, 0, 0, 0);
         step();
         total++;
         if (rv[2] !== (j >= 1 && j <= 16) ||
             (j >= 1 && j <= 16 && rd[2] !== 32'((j - 1) * 3))) begin
            bad++;
            $display("FAIL burst_l2 step%0d: rvalid=%b rdata=%h want %b/%0d",
                     j, rv[2], rd[2], (j >= 1 && j <= 16), (j - 1) * 3);
         end
         for (int k = 0; k < 4; k++) begin
            total++;
            if (rv[k] !== erv[k] || rd[k] !== erd[k]) begin
               bad++;
               $display("FAIL burst_model inst%0d step%0d: rvalid=%b rdata=%h want %b/%h",
                        k, j, rv[k], rd[k], erv[k], erd[k]);
            end
         end
      end
   endtask

   task automatic test_hold();
      drive(1, 4'hf, 1, 32'h55, 0, 0); step();
      drive(0, 0, 0, 0, 1, 1);         step();
      drive(0, 0, 0, 0, 0, 0);         step();
      for (int i = 0; i < 5; i++) begin
         step();
         for (int k = 0; k < 4; k++) begin
            total++;
            if (rv[k] !== 1'b0 || rd[k] !== 32'h55) begin
               bad++;
               $display("FAIL hold inst%0d cyc%0d: rvalid=%b rdata=%h want 0/00000055", k, i, rv[k], rd[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      drive(0, 0, 0, 0, 1, 10); step();
      drive(0, 0, 0, 0, 1, 11); step();
      reset = 1'b1;
      drive(1, 4'hf, 12, 32'hBAD0_BAD0, 1, 12); step();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rv[k] !== 1'b0 || rd[k] !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid inst%0d: rvalid=%b rdata=%h want 0/00000000", k, rv[k], rd[k]);
         end
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 1, 13); step();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rv[k] !== (k < 2) || rd[k] !== ((k < 2) ? 32'd39 : 32'd0)) begin
            bad++;
            $display("FAIL reset_first inst%0d: rvalid=%b rdata=%h want %b/%0d",
                     k, rv[k], rd[k], k < 2, (k < 2) ? 39 : 0);
         end
      end
      drive(0, 0, 0, 0, 1, 12); step();
      drive(0, 0, 0, 0, 0, 0);  step();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rd[k] !== 32'd36) begin
            bad++;
            $display("FAIL reset_retain inst%0d: rdata=%h want 00000024", k, rd[k]);
         end
      end
   endtask

   task automatic test_zero_mask();
      drive(1, 4'hf, 9, 32'h1234_5678, 0, 0); step();
      drive(1, 4'h0, 9, 32'hFFFF_FFFF, 0, 0); step();
      drive(0, 0, 0, 0, 1, 9);                step();
      drive(0, 0, 0, 0, 0, 0);                step();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rd[k] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL zero_mask inst%0d: rdata=%h want 12345678", k, rd[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(1'($urandom), 4'($urandom), $urandom_range(0, 7), $urandom,
               1'($urandom), $urandom_range(0, 7));
         step();
         for (int k = 0; k < 4; k++) begin
            total++;
            if (rv[k] !== erv[k] || rd[k] !== erd[k]) begin
               bad++;
               $display("FAIL random inst%0d cyc%0d: rvalid=%b rdata=%h want %b/%h",
                        k, i, rv[k], rd[k], erv[k], erd[k]);
            end
         end
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem_m[i] = '0;
      for (int k = 0; k < 4; k++) begin erv[k] = 1'b0; erd[k] = '0; end
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      test_reset();
      test_byte_enable();
      test_collision();
      test_back_to_back();
      test_hold();
      test_reset_mid_burst();
      test_zero_mask();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
